// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory bus arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } mem_arb_state_t;

    localparam logic MEM_ARB_PORT_CORE = 1'b0;
    localparam logic MEM_ARB_PORT_EXT  = 1'b1;

    // Round-robin pick: a lone requester wins, a tie goes to the port not granted last.
    function automatic logic mem_arb_pick(input logic [1:0] req, input logic last_grant);
        logic pick;
        if (req == 2'b11) begin
            pick = ~last_grant;
        end else if (req[1]) begin
            pick = MEM_ARB_PORT_EXT;
        end else begin
            pick = MEM_ARB_PORT_CORE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clear/enable cycle counter; expired flags the last allowed wait cycle.
module mem_arb_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_q;

    // Count enabled cycles, saturating at LIMIT so the counter never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Fires on the cycle whose increment would make the count reach LIMIT.
    assign expired = enable && (count_q >= CNT_LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory bus arbiter: one transaction at a time, round-robin grant,
// done/fault pulse back to the owner. Optional bus timeout under MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req,
    input  logic [1:0]                 we,
    input  logic [1:0][ADDR_WIDTH-1:0] addr,
    input  logic [1:0][DATA_WIDTH-1:0] wdata,
    output logic [1:0]                 done,
    output logic [1:0]                 fault,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ack,
    input  logic                       mem_err,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    mem_arb_state_t state_q;
    logic           grant_q;
    logic           last_grant_q;
    logic           pick;
    logic           expired;

    assign pick = mem_arb_pick(req, last_grant_q);

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic tmr_clear;
    logic tmr_enable;

    assign tmr_clear  = (state_q == IDLE) && (|req);
    assign tmr_enable = (state_q == ISSUE) && !mem_ack;

    mem_arb_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_enable),
        .expired(expired)
    );
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES == 0);
    assign expired        = 1'b0;
`endif

    // Transaction FSM; all bus and response outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= MEM_ARB_PORT_CORE;
            last_grant_q <= MEM_ARB_PORT_EXT;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            done         <= '0;
            fault        <= '0;
            rdata        <= '0;
        end else begin
            // done/fault are single-cycle pulses, raised only on entry to RESP.
            done  <= '0;
            fault <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q      <= pick;
                        last_grant_q <= pick;
                        mem_req      <= 1'b1;
                        mem_we       <= we[pick];
                        mem_addr     <= addr[pick];
                        mem_wdata    <= wdata[pick];
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // An ack on the expiry cycle takes priority over the timeout.
                    if (mem_ack) begin
                        rdata          <= mem_rdata;
                        mem_req        <= 1'b0;
                        done[grant_q]  <= 1'b1;
                        fault[grant_q] <= mem_err;
                        state_q        <= RESP;
                    end else if (expired) begin
                        mem_req        <= 1'b0;
                        done[grant_q]  <= 1'b1;
                        fault[grant_q] <= 1'b1;
                        state_q        <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the core's single memory bus between two requesters: port 0 (core fetch/memory stages) and port 1 (external debug/DMA master).
- Runs one transaction at a time with round-robin grant and a done/fault handshake back to the requester.
- Sits between the stage FSM datapath and the memory bus.
- Port 0 `fault` feeds the FSM's `mem_access_fault`.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 16, max cycles waiting for `mem_ack` (≥1)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- req[1:0]  input  2  per-port transaction request; held until `done`
- we[1:0]  input  2  per-port write enable
- addr[1:0]  input  2×ADDR_WIDTH  per-port address
- wdata[1:0]  input  2×DATA_WIDTH  per-port write data
- done[1:0]  output  2  one-cycle completion pulse to the owning port
- fault[1:0]  output  2  qualifies `done`: transaction failed (bus error or timeout)
- rdata  output  DATA_WIDTH  read data, valid with `done`
- mem_req  output  1  bus request, held until ack or timeout
- mem_we  output  1  bus write enable
- mem_addr  output  ADDR_WIDTH  bus address
- mem_wdata  output  DATA_WIDTH  bus write data
- mem_ack  input  1  bus completion
- mem_err  input  1  bus error, qualified by `mem_ack`
- mem_rdata  input  DATA_WIDTH  bus read data, qualified by `mem_ack`

## Operation
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any `req` is high, register the grant index, latch that port's we/addr/wdata into the bus registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester: that port wins.
  - Both requesting: the port not equal to `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - `last_grant` updates on each grant.
- ISSUE:
  - `mem_req`=1 and bus outputs are held stable.
  - On `mem_ack`: capture `mem_rdata` into `rdata` and `mem_err` into the fault flag, drop `mem_req`, go to RESP.
- RESP:
  - `done[grant]`=1 and `fault[grant]`=captured flag for exactly one cycle, then go to IDLE.
  - Other port's `done`/`fault` stay 0.
- The requester must deassert `req` on the edge ending its `done` cycle. A `req` still high in the following IDLE cycle is treated as a new transaction.
- `req` changes from the non-granted port during ISSUE/RESP have no effect. That port is evaluated only in IDLE.
- Reset values:
  - State IDLE, `last_grant`=1, timeout counter 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `done`=0, `fault`=0, `rdata`=0.
- Reset mid-transaction: aborts immediately. `mem_req` drops asynchronously, and no `done` is issued for the aborted transaction.

## Timing
- `req` high at edge 0 → `mem_req` high after edge 1 (ISSUE).
- `mem_ack` sampled at edge k (k≥2) → `done` high for the cycle after edge k → IDLE after edge k+1.
- Minimum latency from `req` to `done`: 2 cycles. Back-to-back transactions: 3 cycles each minimum.
- `rdata` holds its value until the next captured ack.
- Timeout counter:
  - Clears on entering ISSUE and increments each ISSUE cycle without ack.
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Saturating compare, no wrap.
- `mem_ack` in the same cycle the counter reaches TIMEOUT_CYCLES: ack wins and the result is a normal completion.

## Configuration
- MEM_ARBITER_TIMEOUT_EN defined:
  - Counter reaching TIMEOUT_CYCLES in ISSUE without ack → drop `mem_req`, go to RESP with `fault`=1 and `rdata` unchanged.
  - A late `mem_ack` arriving in IDLE/RESP is ignored.
- Not defined:
  - No counter logic; ISSUE waits indefinitely for `mem_ack`.
  - TIMEOUT_CYCLES is unused.

## Structure
- Package `mem_arb_pkg`:
  - State enum `mem_arb_state_t` (IDLE, ISSUE, RESP).
  - Port index constants `MEM_ARB_PORT_CORE`=0 and `MEM_ARB_PORT_EXT`=1.
- One sub-module, `mem_arb_timer`:
  - Clear/enable counter with an `expired` output.
  - Instantiated only under MEM_ARBITER_TIMEOUT_EN.

## Test plan
- Port 0 read of addr 0x100, ack with `mem_rdata`=0xDEADBEEF 3 cycles after `mem_req` → `done[0]`=1, `fault[0]`=0, `rdata`=0xDEADBEEF, `done[1]` stays 0.
- Both ports request in the same cycle after reset → port 0 granted first, port 1 granted in the IDLE after port 0's `done`. Then both request again → port 0 granted (last_grant=1 alternation).
- Port 1 write with `mem_err`=1 on ack → `done[1]`=1, `fault[1]`=1, `mem_we`=1 throughout ISSUE.
- Timeout (macro defined, TIMEOUT_CYCLES=4), no ack → `mem_req` drops after 4 ISSUE cycles, `done[0]`=1, `fault[0]`=1. Ack in the same cycle as expiry → `fault`=0.
- Reset asserted mid-ISSUE → `mem_req`=0 immediately, no `done`. After release, a fresh request completes normally.
